mont_mult_serial: RTL and testbench

//  Bit-serial Montgomery modular multiplier: P = A*B*2^-WIDTH mod M.

---
 rtl/rsa_pkg.sv | 13 +
 rtl/mont_mult_serial.sv | 101 ++++++++++
 tb/tb_mont_mult_serial.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared types for the RSA datapath: Montgomery multiplier state encoding and sizing.
package rsa_pkg;

  typedef enum logic [1:0] {
    MM_IDLE,
    MM_CALC,
    MM_CORR
  } mm_state_t;

  localparam int MM_WIDTH = 8;
  localparam int MM_CNT_W = $clog2(MM_WIDTH);

endpackage

// File: rtl/mont_mult_serial.sv
// Bit-serial Montgomery multiplier, p = a*b*2^-WIDTH mod m, one multiplicand bit per clock.
// Optional operand checking is enabled by defining MONT_MULT_INPUT_CHECK_EN.
module mont_mult_serial
  import rsa_pkg::*;
#(
  parameter int WIDTH = MM_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] p,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mm_state_t        state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH+1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH+1:0] t_add;
  logic [WIDTH+1:0] t_odd;
  logic [WIDTH+1:0] m_ext;
  logic [WIDTH-1:0] acc_sub;
  logic             launch_ok;

  // One Montgomery step: add b if the current a bit is set, make even with m, halve.
  always_comb begin
    m_ext   = {2'b00, m_q};
    t_add   = acc + (a_q[cnt] ? {2'b00, b_q} : '0);
    t_odd   = t_add + (t_add[0] ? m_ext : '0);
    acc_sub = acc[WIDTH-1:0] - m_q;
  end

`ifdef MONT_MULT_INPUT_CHECK_EN
  assign launch_ok = m[0] && (a < m) && (b < m);
`else
  assign launch_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MM_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      m_q   <= '0;
      acc   <= '0;
      cnt   <= '0;
      p     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        MM_IDLE: begin
          if (start && launch_ok) begin
            a_q   <= a;
            b_q   <= b;
            m_q   <= m;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= MM_CALC;
          end
        end
        MM_CALC: begin
          acc <= t_odd >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= MM_CORR;
        end
        MM_CORR: begin
          // acc < 2m here, so a single conditional subtract fully reduces it.
          p     <= (acc >= m_ext) ? acc_sub : acc[WIDTH-1:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= MM_IDLE;
        end
        default: state <= MM_IDLE;
      endcase
    end
  end

`ifdef MONT_MULT_INPUT_CHECK_EN
  // Rejected starts flag err for exactly one cycle and never launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else     err <= (state == MM_IDLE) && start && !launch_ok;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mont_mult_serial.sv
// Self-checking bench for mont_mult_serial (WIDTH=8) against a plain-arithmetic modular model.
module tb_mont_mult_serial;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b, m;
  logic [W-1:0] p;
  logic         busy, done, err;

  int total = 0;
  int bad   = 0;

  mont_mult_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .m(m),
    .p(p), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Reference: the unique x in [0,m) with x*2^W == a*b (mod m).
  function automatic int ref_mont(input int ra, input int rb, input int rm);
    longint prod;
    prod = (longint'(ra) * longint'(rb)) % rm;
    for (int x = 0; x < rm; x++)
      if (((longint'(x) << W) % rm) == prod) return x;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches one op, scrambles inputs while it runs, reports result, latency and busy count.
  task automatic run_op(input int ra, input int rb, input int rm,
                        output int got_p, output int lat, output int busy_cnt);
    a = W'(ra); b = W'(rb); m = W'(rm); start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1; busy_cnt = 0; got_p = -1;
    for (int k = 1; k <= 30; k++) begin
      if (busy) busy_cnt++;
      if (k > 1) begin
        a = W'($urandom); b = W'($urandom); m = W'($urandom);
      end
      tick();
      if (done) begin
        lat = k; got_p = int'(p);
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; m = '0;
    tick(); tick();
    total++;
    if ({p, busy, done, err} !== {8'h00, 3'b000}) begin
      bad++;
      $display("[TB] FAIL reset_state: got p=%h busy=%b done=%b err=%b, want 00 0 0 0", p, busy, done, err);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    int gp, lat, bc;
    int va[4] = '{7, 1, 0, 254};
    int vb[4] = '{5, 1, 9, 254};
    int vm[4] = '{13, 13, 13, 255};
    int vp[4] = '{1, 3, 0, 1};
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vm[i], gp, lat, bc);
      total++;
      if (gp !== vp[i]) begin
        bad++;
        $display("[TB] FAIL directed_p[%0d]: got %0d, want %0d", i, gp, vp[i]);
      end
      total++;
      if (lat !== W + 1 || bc !== W + 1) begin
        bad++;
        $display("[TB] FAIL directed_timing[%0d]: got lat=%0d busy=%0d, want %0d %0d", i, lat, bc, W + 1, W + 1);
      end
    end
  endtask

  task automatic test_random();
    int gp, lat, bc, ra, rb, rm, exp_p;
    for (int i = 0; i < 16; i++) begin
      rm = int'($urandom_range(255, 3)) | 1;
      ra = int'($urandom_range(rm - 1, 0));
      rb = int'($urandom_range(rm - 1, 0));
      exp_p = ref_mont(ra, rb, rm);
      run_op(ra, rb, rm, gp, lat, bc);
      total++;
      if (gp !== exp_p || lat !== W + 1) begin
        bad++;
        $display("[TB] FAIL random[%0d] a=%0d b=%0d m=%0d: got p=%0d lat=%0d, want p=%0d lat=%0d",
                 i, ra, rb, rm, gp, lat, exp_p, W + 1);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    lat = -1;
    a = 8'd7; b = 8'd5; m = 8'd13; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 4) begin a = 8'd3; start = 1'b1; end
      else start = 1'b0;
      tick();
      if (done) begin lat = k; break; end
    end
    start = 1'b0;
    total++;
    if (p !== 8'h01 || lat !== W + 1) begin
      bad++;
      $display("[TB] FAIL start_while_busy: got p=%h lat=%0d, want 01 %0d", p, lat, W + 1);
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL busy_ignore_relaunch: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_reset_mid_op();
    int seen_done;
    seen_done = 0;
    a = 8'd7; b = 8'd5; m = 8'd13; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    total++;
    if (p !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_mid_op: got p=%h busy=%b done=%b, want 00 0 0", p, busy, done);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done || busy) seen_done = 1;
    end
    total++;
    if (seen_done !== 0) begin
      bad++;
      $display("[TB] FAIL reset_no_done: got activity=%0d, want 0", seen_done);
    end
  endtask

  task automatic test_back_to_back();
    int gp, lat, bc, gap, exp2;
    exp2 = ref_mont(200, 100, 211);
    run_op(7, 5, 13, gp, lat, bc);
    // We sit on the done cycle: request the next op immediately.
    a = 8'd200; b = 8'd100; m = 8'd211; start = 1'b1;
    tick();
    start = 1'b0;
    gap = -1;
    for (int k = 2; k <= 30; k++) begin
      tick();
      if (done) begin gap = k; break; end
    end
    total++;
    if (gap !== W + 2 || p !== W'(exp2)) begin
      bad++;
      $display("[TB] FAIL back_to_back: got period=%0d p=%0d, want %0d %0d", gap, p, W + 2, exp2);
    end
  endtask

  task automatic test_input_check();
    int gp, lat, bc;
    logic saw_err, saw_busy;
    int bad_a[2] = '{7, 13};
    int bad_m[2] = '{12, 13};
    for (int i = 0; i < 2; i++) begin
      a = W'(bad_a[i]); b = 8'd5; m = W'(bad_m[i]); start = 1'b1;
      tick();
      start = 1'b0;
      saw_err = err; saw_busy = busy;
      tick();
`ifdef MONT_MULT_INPUT_CHECK_EN
      total++;
      if (saw_err !== 1'b1 || saw_busy !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL input_check[%0d]: got err=%b busy=%b then err=%b busy=%b, want 1 0 0 0",
                 i, saw_err, saw_busy, err, busy);
      end
`else
      total++;
      if (saw_err !== 1'b0 || saw_busy !== 1'b1) begin
        bad++;
        $display("[TB] FAIL input_check_off[%0d]: got err=%b busy=%b, want 0 1", i, saw_err, saw_busy);
      end
      repeat (W + 2) tick();
`endif
    end
    run_op(3, 4, 11, gp, lat, bc);
    total++;
    if (err !== 1'b0 || gp !== ref_mont(3, 4, 11)) begin
      bad++;
      $display("[TB] FAIL input_check_valid: got err=%b p=%0d, want 0 %0d", err, gp, ref_mont(3, 4, 11));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_input_check();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
